// File: rtl/calc_gen.sv
// Four-function decimal calculator: digit entry, add/sub, shift-add multiply, digit-serial display.
// One print beat per cycle for DIGITS cycles; multiply takes W cycles; cmd_ready low while busy or printing.
module calc_gen #(
    parameter int DIGITS = 8,
    localparam int W  = $clog2(10**DIGITS),
    localparam int PW = $clog2(DIGITS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [3:0]    cmd,
    output logic          cmd_ready,
    output logic [1:0]    status,
    output logic [3:0]    data,
    output logic [PW-1:0] pos,
    output logic          data_valid,
    output logic          neg,
    output logic [2:0]    EA
);
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MAXV = W'(10**DIGITS - 1);
    localparam logic [W-1:0] TEN  = W'(10);

    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_CLR = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    typedef enum logic [2:0] {
        S_ENTRY_A = 3'd0,
        S_ENTRY_B = 3'd1,
        S_CALC    = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_e;

    state_e        state_q;
    logic [W-1:0]  entry_q, rega_q, regb_q, result_q, acc_q, shadow_q;
    logic [3:0]    op_q;
    logic          neg_q, ovf_q, print_q;
    logic [CW-1:0] mcnt_q;
    logic [PW-1:0] pos_q;

    logic          accept, is_dig, is_op, ext_ok, a_ge_b;
    logic [W+3:0]  ext;
    logic [W:0]    sum;
    logic [W+1:0]  acc_nx;
    logic [CW-1:0] bit_idx;

    assign cmd_ready  = !print_q && (state_q != S_CALC);
    assign accept     = cmd_valid && cmd_ready;
    assign data_valid = print_q;
    assign pos        = pos_q;
    assign neg        = neg_q;
    assign EA         = state_q;

    always_comb begin
        status = 2'b10;
        if (print_q)               status = 2'b11;
        else if (state_q == S_CALC) status = 2'b01;
        else if (state_q == S_ERR)  status = 2'b00;
    end

    // Above the most significant nonzero digit the shadow has been divided down to zero.
    assign data = (pos_q != '0 && shadow_q == '0) ? 4'hF : 4'(shadow_q % TEN);

    always_comb begin
        is_dig  = (cmd <= 4'd9);
        is_op   = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_MUL);
        ext     = ({4'b0, entry_q} * (W+4)'(10)) + (W+4)'(cmd);
        ext_ok  = (ext <= {4'b0, MAXV});
        sum     = {1'b0, rega_q} + {1'b0, entry_q};
        a_ge_b  = (rega_q >= entry_q);
        bit_idx = CW'(W-1) - mcnt_q;
        // MSB-first shift-add: the partial product only grows, so a sticky overflow is exact.
        acc_nx  = {1'b0, acc_q, 1'b0} + {2'b0, (regb_q[bit_idx] ? rega_q : '0)};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_ENTRY_A;
            entry_q  <= '0;
            rega_q   <= '0;
            regb_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            shadow_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            print_q  <= 1'b0;
            mcnt_q   <= '0;
            pos_q    <= '0;
        end else begin
            if (print_q) begin
                shadow_q <= shadow_q / TEN;
                if (pos_q == PW'(DIGITS-1)) begin
                    print_q <= 1'b0;
                    pos_q   <= '0;
                end else begin
                    pos_q <= pos_q + 1'b1;
                end
            end

            if (accept && cmd == CMD_CLR) begin
                state_q  <= S_ENTRY_A;
                entry_q  <= '0;
                rega_q   <= '0;
                regb_q   <= '0;
                result_q <= '0;
                op_q     <= '0;
                neg_q    <= 1'b0;
                print_q  <= 1'b1;
                shadow_q <= '0;
            end else begin
                case (state_q)
                    S_ENTRY_A, S_ENTRY_B: if (accept) begin
                        if (is_dig) begin
                            if (ext_ok) begin
                                entry_q  <= ext[W-1:0];
                                print_q  <= 1'b1;
                                shadow_q <= ext[W-1:0];
                            end
                        end else if (cmd == CMD_BS) begin
                            entry_q  <= entry_q / TEN;
                            print_q  <= 1'b1;
                            shadow_q <= entry_q / TEN;
                        end else if (is_op) begin
                            op_q <= cmd;
                            if (state_q == S_ENTRY_A) begin
                                rega_q   <= entry_q;
                                entry_q  <= '0;
                                state_q  <= S_ENTRY_B;
                                print_q  <= 1'b1;
                                shadow_q <= '0;
                            end
                        end else if (cmd == CMD_EQ && state_q == S_ENTRY_B) begin
                            regb_q <= entry_q;
                            if (op_q == CMD_ADD) begin
                                if (sum > {1'b0, MAXV}) begin
                                    state_q <= S_ERR;
                                end else begin
                                    result_q <= sum[W-1:0];
                                    neg_q    <= 1'b0;
                                    state_q  <= S_DONE;
                                    print_q  <= 1'b1;
                                    shadow_q <= sum[W-1:0];
                                end
                            end else if (op_q == CMD_SUB) begin
                                result_q <= a_ge_b ? rega_q - entry_q : entry_q - rega_q;
                                shadow_q <= a_ge_b ? rega_q - entry_q : entry_q - rega_q;
                                neg_q    <= !a_ge_b;
                                state_q  <= S_DONE;
                                print_q  <= 1'b1;
                            end else begin
                                acc_q   <= '0;
                                ovf_q   <= 1'b0;
                                mcnt_q  <= '0;
                                state_q <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        acc_q  <= acc_nx[W-1:0];
                        ovf_q  <= ovf_q || (acc_nx > {2'b0, MAXV});
                        mcnt_q <= mcnt_q + 1'b1;
                        if (mcnt_q == CW'(W-1)) begin
                            if (ovf_q || (acc_nx > {2'b0, MAXV})) begin
                                state_q <= S_ERR;
                            end else begin
                                result_q <= acc_nx[W-1:0];
                                neg_q    <= 1'b0;
                                state_q  <= S_DONE;
                                print_q  <= 1'b1;
                                shadow_q <= acc_nx[W-1:0];
                            end
                        end
                    end
                    S_DONE: if (accept) begin
                        if (is_dig) begin
                            entry_q  <= W'(cmd);
                            neg_q    <= 1'b0;
                            state_q  <= S_ENTRY_A;
                            print_q  <= 1'b1;
                            shadow_q <= W'(cmd);
                        end else if (is_op && !neg_q) begin
                            rega_q   <= result_q;
                            op_q     <= cmd;
                            entry_q  <= '0;
                            state_q  <= S_ENTRY_B;
                            print_q  <= 1'b1;
                            shadow_q <= '0;
                        end
                    end
                    S_ERR: ;
                    default: state_q <= S_ENTRY_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_gen.sv
// Randomized and directed bench for calc_gen against an integer-level calculator model.
module tb_calc_gen;
    localparam int     DIGITS = 8;
    localparam int     W      = 27;
    localparam longint MAXV   = 99999999;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_ready, data_valid, neg;
    logic [1:0] status;
    logic [3:0] data;
    logic [2:0] pos;
    logic [2:0] EA;

    calc_gen #(.DIGITS(DIGITS)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .status(status), .data(data), .pos(pos),
        .data_valid(data_valid), .neg(neg), .EA(EA)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Calculator model: plain integers, states named by their EA code.
    int     m_st, m_op;
    longint m_entry, m_a, m_res;
    bit     m_neg;

    task automatic model_reset();
        m_st = 0; m_op = 0; m_entry = 0; m_a = 0; m_res = 0; m_neg = 0;
    endtask

    task automatic model_cmd(input int c, output bit pr, output longint pv, output int busy);
        longint b, r;
        bit ok;
        pr = 0; pv = 0; busy = 0; r = 0; ok = 0;
        if (c == 13) begin
            model_reset();
            pr = 1;
        end else if (m_st == 0 || m_st == 1) begin
            if (c <= 9) begin
                if (m_entry * 10 + c <= MAXV) begin
                    m_entry = m_entry * 10 + c; pr = 1; pv = m_entry;
                end
            end else if (c == 15) begin
                m_entry = m_entry / 10; pr = 1; pv = m_entry;
            end else if (c >= 10 && c <= 12) begin
                m_op = c;
                if (m_st == 0) begin
                    m_a = m_entry; m_entry = 0; m_st = 1; pr = 1;
                end
            end else if (c == 14 && m_st == 1) begin
                b = m_entry;
                if (m_op == 10) begin
                    r = m_a + b; ok = (r <= MAXV); m_neg = 0;
                end else if (m_op == 11) begin
                    ok = 1;
                    if (m_a >= b) begin r = m_a - b; m_neg = 0; end
                    else begin r = b - m_a; m_neg = 1; end
                end else begin
                    r = m_a * b; ok = (r <= MAXV); busy = W; m_neg = 0;
                end
                if (ok) begin m_res = r; m_st = 3; pr = 1; pv = r; end
                else m_st = 4;
            end
        end else if (m_st == 3) begin
            if (c <= 9) begin
                m_entry = c; m_neg = 0; m_st = 0; pr = 1; pv = c;
            end else if (c >= 10 && c <= 12 && !m_neg) begin
                m_a = m_res; m_op = c; m_entry = 0; m_st = 1; pr = 1;
            end
        end
    endtask

    function automatic longint exp_digits(input longint v);
        longint p = 1, d, acc = 0;
        for (int i = 0; i < DIGITS; i++) begin
            d = (i == 0 || v / p != 0) ? (v / p) % 10 : 15;
            acc |= d << (4 * i);
            p *= 10;
        end
        return acc;
    endfunction

    function automatic longint exp_positions();
        longint acc = 0;
        for (int i = 0; i < DIGITS; i++) acc |= longint'(i) << (3 * i);
        return acc;
    endfunction

    task automatic send(input int c);
        bit pr;
        longint pv, dpk, ppk;
        int busy, nb, first, nbusy, rdy_bad, waitc;
        @(negedge clock);
        waitc = 0;
        while (!cmd_ready && waitc < 100) begin
            @(negedge clock);
            waitc++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        if (cmd_ready) begin
            cmd_valid = 1'b1;
            cmd = 4'(c);
            model_cmd(c, pr, pv, busy);
            @(posedge clock);
            #1 cmd_valid = 1'b0;
            nb = 0; first = -1; nbusy = 0; rdy_bad = 0; dpk = 0; ppk = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clock);
                if (status == 2'b01) nbusy++;
                if (data_valid) begin
                    if (first < 0) first = k;
                    if (nb < DIGITS) begin
                        dpk |= longint'(data) << (4 * nb);
                        ppk |= longint'(pos) << (3 * nb);
                    end
                    nb++;
                    if (cmd_ready) rdy_bad++;
                end
                if (cmd_ready) break;
            end
            chk("settled_ready", cmd_ready, 1);
            chk("beat_count", nb, pr ? DIGITS : 0);
            chk("busy_cycles", nbusy, busy);
            if (pr) begin
                chk("print_start", first, busy);
                chk("print_digits", dpk, exp_digits(pv));
                chk("print_pos", ppk, exp_positions());
                chk("ready_in_print", rdy_bad, 0);
            end
            chk("neg", neg, m_neg);
            chk("EA", EA, m_st);
            chk("status", status, (m_st == 4) ? 0 : 2);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_EA"}, EA, 0);
        chk({tag, "_status"}, status, 2);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_data"}, data, 0);
        chk({tag, "_pos"}, pos, 0);
        chk({tag, "_dvalid"}, data_valid, 0);
        chk({tag, "_neg"}, neg, 0);
    endtask

    initial begin
        int r;
        model_reset();
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        send(1); send(2); send(3);
        send(13); send(1); send(2); send(10); send(3); send(0); send(14);
        send(15); send(13);
        send(5); send(11); send(1); send(2); send(14); send(10);
        send(13); send(9); send(9); send(9); send(9); send(12);
        send(9); send(9); send(9); send(9); send(14);
        send(13);
        for (int i = 0; i < 8; i++) send(9);
        send(10); send(1); send(14); send(5); send(13);

        // Reset asserted on the third beat of a print.
        @(negedge clock);
        cmd_valid = 1'b1; cmd = 4'd4;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("beat3_pos", pos, 2);
        chk("beat3_valid", data_valid, 1);
        reset = 1'b0;
        #1 check_reset_outputs("midprint");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        send(7);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      send($urandom_range(0, 9));
            else if (r < 63) send(10);
            else if (r < 70) send(11);
            else if (r < 80) send(12);
            else if (r < 88) send(14);
            else if (r < 93) send(15);
            else             send(13);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/calc_gen.md
CALC_GEN -- requirements
Module: calc_gen

Interface
REQ-001 SHALL have parameter DIGITS, default 8: decimal digits per operand and per result (range 2..9).
REQ-002 SHALL have localparam W = $clog2(10**DIGITS) (27 for DIGITS=8) and MAXV = 10**DIGITS-1; all operand and result registers are W bits.
REQ-003 SHALL have port: clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: cmd_valid  input  1  cmd is presented this cycle.
REQ-006 SHALL have port: cmd  input  4  0-9 digit, 10 add, 11 sub, 12 mul, 13 clear, 14 equals, 15 backspace.
REQ-007 SHALL have port: cmd_ready  output  1  block can accept a command this cycle.
REQ-008 SHALL have port: status  output  2  00 error, 01 busy, 10 ready, 11 printing.
REQ-009 SHALL have port: data  output  4  display digit, 4'hF = blank.
REQ-010 SHALL have port: pos  output  $clog2(DIGITS)  display position of data, 0 = least significant.
REQ-011 SHALL have port: data_valid  output  1  data/pos valid this cycle.
REQ-012 SHALL have port: neg  output  1  displayed value is negative.
REQ-013 SHALL have port: EA  output  3  current FSM state (debug).

Function
REQ-014 SHALL accept a command only on a cycle where cmd_valid && cmd_ready; cmd_ready = 1 only in ENTRY_A, ENTRY_B, DONE and ERR with no print in progress.
REQ-015 SHALL implement states ENTRY_A=0, ENTRY_B=1, CALC=2, DONE=3, ERR=4, with printing as a sub-phase (PRINT flag) that freezes state transitions.
REQ-016 ENTRY_A/ENTRY_B digit: entry <= entry*10+cmd, then print entry; if result would exceed MAXV, command dropped, no print.
REQ-017 Backspace in ENTRY_A/ENTRY_B: entry <= entry/10, then print entry.
REQ-018 Operator (10-12) in ENTRY_A: regA <= entry, op <= cmd, entry <= 0, go to ENTRY_B, print 0.
REQ-019 Operator in ENTRY_B: op <= cmd, entry unchanged, no print; equals in ENTRY_A: dropped.
REQ-020 Equals in ENTRY_B: regB <= entry; add/sub go straight to DONE with result; mul goes to CALC.
REQ-021 Add: sum > MAXV -> ERR; else result = sum, neg=0.
REQ-022 Sub: regA >= regB -> result = regA-regB, neg=0; else result = regB-regA, neg=1.
REQ-023 Mul: shift-add over exactly W cycles in CALC, status=01, cmd_ready=0; product > MAXV (checked with W+1-bit accumulator / carry tracking) -> ERR, else DONE.
REQ-024 Entering DONE SHALL print result; DONE digit: start new ENTRY_A entry = digit, neg<=0; DONE operator with neg=0: regA <= result, chain into ENTRY_B; with neg=1: dropped.
REQ-025 Clear (13) in any accepting state: all registers zero, neg=0, go to ENTRY_A, print 0.
REQ-026 ERR: status=00, data_valid=0; only clear accepted, all else dropped.
REQ-027 Print starts cycle after trigger: data_valid high for exactly DIGITS consecutive cycles, pos 0..DIGITS-1, data = decimal digit at pos, LSD first.
REQ-028 Positions above the most significant nonzero digit SHALL show 4'hF; pos 0 always shows a digit (value 0 -> 0,F,F,...).
REQ-029 status = 11 while printing, 01 in CALC, 00 in ERR, else 10; cmd_ready returns the cycle after last beat.
REQ-030 Digit extraction SHALL use a shadow copy of the value so entry/result registers are unaffected by printing.

Reset
REQ-031 reset low SHALL immediately force EA=ENTRY_A, status=10, cmd_ready=1, data=0, pos=0, data_valid=0, neg=0, all internal registers and PRINT flag zero, including mid-print or mid-CALC.
REQ-032 After reset deasserts, first command SHALL be accepted on the first rising edge with cmd_valid=1.

Verification (DIGITS=8)
REQ-033 Digits 1,2,3 -> after '3', 8 beats data=3,2,1,F,F,F,F,F pos=0..7; cmd_ready low during each print.
REQ-034 1,2,add,3,0,equals -> DONE prints 2,4,F...F, neg=0; then backspace dropped, clear prints 0,F...F.
REQ-035 5,sub,1,2,equals -> prints 7,F...F, neg=1; following add dropped, EA stays DONE.
REQ-036 9999 mul 9999 equals -> status=01 for exactly 27 cycles, then prints 1,0,0,0,8,9,9,9 (99980001).
REQ-037 99999999 add 1 equals -> status=00, no data_valid; digit dropped; clear -> status=10, EA=ENTRY_A.
REQ-038 reset pulsed low at beat 3 of a print -> outputs at reset values same cycle; next digit 7 prints 7,F...F.
